// File: rtl/ped_req_ctrl_if.sv
// Pedestrian request controller signal bundle.
// The master side drives the button and red-phase inputs; the slave side is the controller.
interface ped_req_ctrl_if;
    logic ped_btn;
    logic led_red;
    logic ped_req;
    logic walk;
    logic dont_walk;

    modport master (output ped_btn, led_red, input ped_req, walk, dont_walk);
    modport slave  (input ped_btn, led_red, output ped_req, walk, dont_walk);
endinterface

// File: rtl/ped_req_ctrl.sv
// Pedestrian request controller: synchronizes and debounces the button, raises a request,
// and runs a walk / flashing-clearance sequence aligned to the start of a red phase.
module ped_req_ctrl #(
    parameter int DEB_COUNT   = 1_000_000,
    parameter int WALK_COUNT  = 250_000_000,
    parameter int CLEAR_COUNT = 150_000_000,
    parameter int FLASH_COUNT = 12_500_000
) (
    input  logic          clk,
    input  logic          rst,
    ped_req_ctrl_if.slave bus
);
    localparam int PMAX = (WALK_COUNT > CLEAR_COUNT) ? WALK_COUNT : CLEAR_COUNT;
    localparam int DW   = $clog2(DEB_COUNT + 1);
    localparam int PW   = $clog2(PMAX + 1);
    localparam int FW   = $clog2(FLASH_COUNT + 1);

    typedef enum logic [1:0] {IDLE, PENDING, WALK, CLEAR} state_t;

    state_t        state, next_state;
    logic          sync1, sync2, deb, deb_d, red_d;
    logic [DW-1:0] deb_cnt;
    logic [PW-1:0] phase_cnt;
    logic [FW-1:0] flash_cnt;
    logic          ped_req_q, walk_q, dont_walk_q;
    logic          ped_req_n, walk_n, dont_walk_n;
    logic          press, red_onset;

    // Input conditioning: synchronizer, debounce, edge detectors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb     <= 1'b0;
            deb_d   <= 1'b0;
            red_d   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1 <= bus.ped_btn;
            sync2 <= sync1;
            deb_d <= deb;
            red_d <= bus.led_red;
            if (sync2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEB_COUNT - 1)) begin
                deb     <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    assign press     = deb & ~deb_d;
    assign red_onset = bus.led_red & ~red_d;

    // State register; outputs are registered from the next-state decode so they come from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            flash_cnt   <= '0;
            ped_req_q   <= 1'b0;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
        end else begin
            state       <= next_state;
            ped_req_q   <= ped_req_n;
            walk_q      <= walk_n;
            dont_walk_q <= dont_walk_n;
            if (next_state != state) begin
                phase_cnt <= '0;
                flash_cnt <= '0;
            end else begin
                if (phase_cnt != '1)
                    phase_cnt <= phase_cnt + PW'(1);
                if (flash_cnt == FW'(FLASH_COUNT - 1))
                    flash_cnt <= '0;
                else
                    flash_cnt <= flash_cnt + FW'(1);
            end
        end
    end

    // Losing red during walk or clearance aborts ahead of any timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (press) next_state = PENDING;
            PENDING: if (red_onset) next_state = WALK;
            WALK: begin
                if (!bus.led_red)
                    next_state = IDLE;
                else if (phase_cnt == PW'(WALK_COUNT - 1))
                    next_state = CLEAR;
            end
            CLEAR: begin
                if (!bus.led_red)
                    next_state = IDLE;
                else if (phase_cnt == PW'(CLEAR_COUNT - 1))
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ped_req_n   = (next_state == PENDING);
        walk_n      = (next_state == WALK);
        dont_walk_n = 1'b1;
        case (next_state)
            WALK:  dont_walk_n = 1'b0;
            CLEAR: begin
                if (state != CLEAR)
                    dont_walk_n = 1'b1;
                else if (flash_cnt == FW'(FLASH_COUNT - 1))
                    dont_walk_n = ~dont_walk_q;
                else
                    dont_walk_n = dont_walk_q;
            end
            default: dont_walk_n = 1'b1;
        endcase
    end

    assign bus.ped_req   = ped_req_q;
    assign bus.walk      = walk_q;
    assign bus.dont_walk = dont_walk_q;
endmodule

// File: tb/tb_ped_req_ctrl.sv
// Directed bench for ped_req_ctrl with short debounce/phase parameters.
module tb_ped_req_ctrl;
    localparam int DEB    = 4;
    localparam int WALKC  = 10;
    localparam int CLEARC = 6;
    localparam int FLASHC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [5:0] clr_pat = 6'b110011;

    ped_req_ctrl_if bus();

    ped_req_ctrl #(
        .DEB_COUNT  (DEB),
        .WALK_COUNT (WALKC),
        .CLEAR_COUNT(CLEARC),
        .FLASH_COUNT(FLASHC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic pr, input logic w, input logic dw);
        chk({tag, ".ped_req"}, bus.ped_req, pr);
        chk({tag, ".walk"}, bus.walk, w);
        chk({tag, ".dont_walk"}, bus.dont_walk, dw);
    endtask

    initial begin
        bus.ped_btn = 1'b0;
        bus.led_red = 1'b0;
        rst = 1'b1;
        tick(3);
        chk_out("reset", 0, 0, 1);
        rst = 1'b0;
        tick(2);
        chk_out("idle", 0, 0, 1);

        // Clean press: request exactly DEB+3 edges after first sampled high.
        bus.ped_btn = 1'b1;
        for (int i = 1; i <= DEB + 2; i++) begin
            tick();
            chk("lat_pre", bus.ped_req, 1'b0);
        end
        tick();
        chk_out("lat_hit", 1, 0, 1);
        tick(20);
        chk_out("hold_no_red", 1, 0, 1);

        // Full walk / clearance cycle.
        bus.led_red = 1'b1;
        for (int i = 0; i < WALKC; i++) begin
            tick();
            chk_out("walk", 0, 1, 0);
        end
        for (int i = 0; i < CLEARC; i++) begin
            tick();
            chk_out("clear", 0, 0, clr_pat[5-i]);
        end
        tick();
        chk_out("idle_after", 0, 0, 1);
        tick(5);
        chk_out("no_requeue", 0, 0, 1);

        // Bounce: toggles every 2 cycles never complete debounce.
        bus.ped_btn = 1'b0;
        bus.led_red = 1'b0;
        tick(10);
        for (int i = 0; i < 10; i++) begin
            bus.ped_btn = ~bus.ped_btn;
            tick(2);
            chk("bounce_mid", bus.ped_req, 1'b0);
        end
        bus.ped_btn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("bounce_after", bus.ped_req, 1'b0);
        end

        // Red already on before the press needs a fresh onset.
        bus.led_red = 1'b1;
        tick(3);
        bus.ped_btn = 1'b1;
        tick(DEB + 3);
        chk_out("red_pre_req", 1, 0, 1);
        tick(5);
        chk_out("red_no_walk", 1, 0, 1);
        bus.led_red = 1'b0;
        tick(2);
        chk_out("red_drop", 1, 0, 1);
        bus.led_red = 1'b1;
        tick();
        chk_out("fresh_onset", 0, 1, 0);

        // Abort at WALK cycle 5.
        tick(5);
        chk_out("walk_c5", 0, 1, 0);
        bus.led_red = 1'b0;
        tick();
        chk_out("abort", 0, 0, 1);
        tick(3);
        bus.led_red = 1'b1;
        tick(3);
        chk_out("abort_no_rereq", 0, 0, 1);
        bus.ped_btn = 1'b0;
        tick(8);
        bus.ped_btn = 1'b1;
        tick(DEB + 2);
        chk("second_pre", bus.ped_req, 1'b0);
        tick();
        chk_out("second_press", 1, 0, 1);

        // Asynchronous reset mid-walk, between clock edges.
        bus.led_red = 1'b0;
        tick(2);
        bus.led_red = 1'b1;
        tick();
        chk_out("walk2", 0, 1, 0);
        tick(3);
        #2 rst = 1'b1;
        #1 chk_out("async_rst", 0, 0, 1);
        tick(2);
        chk_out("rst_held", 0, 0, 1);
        rst = 1'b0;

        // Button already high at reset release still yields a press.
        for (int i = 1; i <= DEB + 2; i++) begin
            tick();
            chk("post_rst_pre", bus.ped_req, 1'b0);
        end
        tick();
        chk_out("post_rst_press", 1, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ped_req_ctrl.md
PED_REQ_CTRL -- requirements
Module: ped_req_ctrl

Interface
REQ-001 Parameter DEB_COUNT, default 1_000_000: consecutive clk cycles ped_btn must differ from its debounced value before that value updates (20 ms at 50 MHz).
REQ-002 Parameter WALK_COUNT, default 250_000_000: clk cycles of steady walk.
REQ-003 Parameter CLEAR_COUNT, default 150_000_000: clk cycles of flashing dont_walk clearance.
REQ-004 Parameter FLASH_COUNT, default 12_500_000: clk cycles per dont_walk toggle during clearance.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  system clock, 50 MHz; all flops on its rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 ped_btn  input  1  raw pedestrian button, active-high, asynchronous, bouncing.
REQ-009 led_red  input  1  red-phase indication from the traffic-light controller, synchronous to clk.
REQ-010 ped_req  output  1  registered pedestrian request to the traffic-light controller, held until served.
REQ-011 walk  output  1  registered walk lamp.
REQ-012 dont_walk  output  1  registered don't-walk lamp.

Function
REQ-013 ped_btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Debounce: a counter SHALL increment each cycle the synchronized value differs from the debounced value and clear to 0 on any cycle they match; the debounced value SHALL update on the cycle the counter reaches DEB_COUNT-1, and the counter then clears.
REQ-015 A press event SHALL be a 0->1 transition of the debounced value, one cycle wide.
REQ-016 A red-onset event SHALL be led_red=1 while its one-cycle-delayed copy is 0.
REQ-017 State machine states: IDLE, PENDING, WALK, CLEAR.
REQ-018 IDLE: ped_req=0, walk=0, dont_walk=1; press -> PENDING.
REQ-019 PENDING: ped_req=1, walk=0, dont_walk=1; red-onset -> WALK. A red phase already in progress on entry SHALL NOT start WALK; a fresh red-onset is required.
REQ-020 WALK: ped_req=0, walk=1, dont_walk=0; after WALK_COUNT cycles in state -> CLEAR.
REQ-021 CLEAR: ped_req=0, walk=0; dont_walk=1 on entry, inverting every FLASH_COUNT cycles; after CLEAR_COUNT cycles in state -> IDLE with dont_walk=1.
REQ-022 led_red=0 in any cycle of WALK or CLEAR SHALL force the next state to IDLE (abort); this takes priority over the timeout transitions.
REQ-023 Press events in PENDING, WALK or CLEAR SHALL be ignored and SHALL NOT be queued.
REQ-024 Latency: with ped_btn held stable high, ped_req SHALL assert exactly DEB_COUNT+3 rising edges after the first edge that samples ped_btn=1.
REQ-025 walk SHALL assert on the edge following the red-onset cycle.
REQ-026 Phase counters SHALL be wide enough for their parameters, clear on every state entry, and never wrap.
REQ-027 All outputs SHALL be driven directly from flops.

Reset
REQ-028 While rst=1: state=IDLE, ped_req=0, walk=0, dont_walk=1, synchronizer flops=0, debounced value=0, debounce and phase counters=0, led_red delay flop=0.
REQ-029 Reset asserted mid-operation (any state) SHALL immediately force the REQ-028 values; a request in progress is discarded.
REQ-030 After rst deasserts with ped_btn already high, a press SHALL be generated once debounce completes (debounced value starts at 0).

Verification
Use DEB_COUNT=4, WALK_COUNT=10, CLEAR_COUNT=6, FLASH_COUNT=2.
REQ-031 Clean press: ped_btn 0->1 held, led_red=0 -> ped_req=1 exactly 7 edges later; it stays 1 indefinitely without red.
REQ-032 Bounce: ped_btn toggles every 2 cycles for 20 cycles, then 0 -> ped_req never asserts.
REQ-033 Full cycle: in PENDING, raise led_red -> walk=1 for 10 cycles, then dont_walk pattern 1,1,0,0,1,1 over 6 cycles, then IDLE with dont_walk=1 and ped_req=0.
REQ-034 Red already on: led_red=1 before the press -> stays PENDING; drop led_red, raise it again -> WALK starts on the edge after the rise.
REQ-035 Abort: led_red drops at cycle 5 of WALK -> next edge walk=0, dont_walk=1, IDLE; a second press is required to re-request.
REQ-036 Async reset: assert rst mid-WALK between clock edges -> walk=0, dont_walk=1, ped_req=0 immediately, with no clock edge required.
